pwm_multi_controller: RTL and testbench
=======================================

# pwm_multi_controller

Multi-channel, parametrised PWM generator with per-channel push-button duty adjustment. It is the next generation of the single-channel key-driven PWM block. New behaviour:
- one shared period counter drives `CH_NUM` independent outputs;
- keys are edge-detected, so one press gives one step;
- duty changes are double-buffered and take effect only at a period boundary, so no output glitches;
- center-aligned mode is available as a compile option.

The block sits between the debounced key inputs and the LED/motor drive pins.

## Interface
- `CNT_NUM`, 8: period length in counter steps, ≥2. Duty range is 0..`CNT_NUM`.
- `CH_NUM`, 2: number of PWM channels, ≥1.
- `STEP`, 1: duty increment/decrement per key press, 1..`CNT_NUM`.
- `DUTY_INIT`, `CNT_NUM`/2: duty value of every channel after reset, 0..`CNT_NUM`.
- Derived width: W = ceil(log2(`CNT_NUM`+1)).

Ports:
- `clk` input 1: the single clock; all logic on its rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `key_up` input `CH_NUM`: per-channel increase request, level, already debounced.
- `key_down` input `CH_NUM`: per-channel decrease request, level, already debounced.
- `out` output `CH_NUM`: registered PWM outputs, active-high.
- `period_start` output 1: one-cycle pulse on the first cycle of each period.
- `duty` output `CH_NUM`*W: committed (active) duty per channel; channel i occupies bits [i*W +: W].

## Operation
- **Counter (edge-aligned):** `cnt` runs 0,1,…,`CNT_NUM`-1, then wraps to 0. Period is `CNT_NUM` cycles.
- **Key edge detect:** each channel registers `key_up` and `key_down`. A press is a 0→1 transition. The previous-value registers reset to 0, so a key held high through reset release counts as one press. A held key produces no further steps.
- **Pending duty (`duty_nxt`):** updated per channel on a press.
  - Up: `duty_nxt` = min(`duty_nxt`+`STEP`, `CNT_NUM`).
  - Down: `duty_nxt` = max(`duty_nxt`−`STEP`, 0).
  - Compute in W+1 bits so the sum cannot overflow and the difference cannot underflow.
  - Up and down edges in the same cycle on one channel: no change.
  - Channels are fully independent.
- **Commit:** on the clock edge where `cnt` wraps to period start, `duty` ← `duty_nxt` for all channels. `duty` never changes at any other time.
- **Compare:** `out[i]` is registered from (`cnt` < `duty[i]`), evaluated with the `cnt` and `duty` values of the same cycle.
  - `duty`=0: `out` constant 0.
  - `duty`=`CNT_NUM`: `out` constant 1.
- **Reset values:**
  - `cnt`=0; `out`=0; `period_start`=0.
  - `duty` = `duty_nxt` = `DUTY_INIT` on all channels.
  - Edge registers = 0.
- **Reset mid-period:** all of the above state is reinstated on the next edge. Any pending duty change is discarded.

## Timing
- `out` lags `cnt` by 1 cycle. The first period after reset begins with `cnt`=0 in the first cycle after `rst` falls.
- `period_start` is registered and high for exactly 1 cycle. It aligns with the first `out` cycle of each period: high when the registered `cnt` value is the period's first value.
- Key to committed duty: the press is detected 1 cycle after the key rises. It commits at the next period boundary. It is visible on `out` 1 cycle after commit.
  - Worst case: `CNT_NUM`+2 cycles from key rise to `out`.
  - A press landing in the wrap cycle is committed at the following boundary, not the current one.
- Duty is sampled for the whole period, so no period ever sees a partial duty value.

## Configuration
- `PWM_CENTER_ALIGN_EN` undefined: edge-aligned behaviour as above.
- `PWM_CENTER_ALIGN_EN` defined: center-aligned mode.
  - `cnt` counts up 0..`CNT_NUM`-1, then down `CNT_NUM`-1..0. Each extreme value is held for 2 consecutive cycles.
  - Period is 2·`CNT_NUM` cycles.
  - Period start is the first cycle of the up phase (`cnt`=0 after a down phase).
  - The same comparison is used, so high time is 2·`duty` cycles, centered on the period boundary.
  - Commit and `period_start` occur at that boundary. A direction flag resets to "up".

## Test plan
1. Reset with defaults (`CNT_NUM`=8, `CH_NUM`=2, `STEP`=1, `DUTY_INIT`=4), release → both `out` = 1,1,1,1,0,0,0,0 repeating from cycle 2; `period_start` every 8 cycles; `duty`=4,4.
2. Single `key_up[0]` pulse mid-period → `duty[0]` stays 4 until the next boundary, then 5; `out[0]` high 5 of 8 cycles; channel 1 unchanged.
3. Hold `key_up[0]` for 40 cycles, plus 6 separate presses → `duty[0]` saturates at 8 and `out[0]` stays constant 1; 9 `key_down` presses → `duty[0]`=0, `out[0]` constant 0, never wraps.
4. `key_up[1]` and `key_down[1]` rise in the same cycle → `duty[1]` unchanged. `STEP`=3, `duty`=7, press up → 8 (saturated). Then press down twice → 5, 2.
5. Assert `rst` for 1 cycle mid-period with a pending change → `out`=0, `cnt`=0, `duty`=4 on all channels; the pending change is lost.
6. With `PWM_CENTER_ALIGN_EN`, `duty`=3 → `cnt` 0..7,7..0; `out` high 6 of 16 cycles, centered on the boundary; `period_start` every 16 cycles.

Source files
------------

// File: rtl/pwm_multi_controller_if.sv
// Key inputs, PWM outputs and committed duty of one pwm_multi_controller.
// slave: the controller side; master: the key source / output consumer side.
interface pwm_multi_controller_if #(
   parameter int CH_NUM = 2,
   parameter int W      = 4
);
   logic [CH_NUM-1:0]   key_up;
   logic [CH_NUM-1:0]   key_down;
   logic [CH_NUM-1:0]   out;
   logic                period_start;
   logic [CH_NUM*W-1:0] duty;

   modport master (
      output key_up, key_down,
      input  out, period_start, duty
   );

   modport slave (
      input  key_up, key_down,
      output out, period_start, duty
   );
endinterface

// File: rtl/pwm_multi_controller.sv
// Multi-channel PWM: one shared period counter, per-channel duty stepped by edge-detected keys.
// Latency: out registered 1 cycle after cnt; a key press commits at the next period boundary.
// No backpressure (level key inputs). Define PWM_CENTER_ALIGN_EN for up/down center-aligned counting.
module pwm_multi_controller #(
   parameter int CNT_NUM   = 8,
   parameter int CH_NUM    = 2,
   parameter int STEP      = 1,
   parameter int DUTY_INIT = CNT_NUM / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   pwm_multi_controller_if.slave bus
);
   localparam int W = $clog2(CNT_NUM + 1);
   localparam logic [W-1:0] CNT_LAST = W'(CNT_NUM - 1);
   localparam logic [W:0]   CNT_MAX  = (W+1)'(CNT_NUM);
   localparam logic [W:0]   STEP_V   = (W+1)'(STEP);
   localparam logic [W-1:0] DUTY_RST = W'(DUTY_INIT);

   logic [W-1:0]              cnt;
   logic [W-1:0]              cnt_next;
   logic                      commit;
   logic                      at_start;
   logic [CH_NUM-1:0]         up_r, up_prev, dn_r, dn_prev;
   logic [CH_NUM-1:0]         up_press, dn_press;
   logic [CH_NUM-1:0][W-1:0]  duty_nxt;
   logic [CH_NUM-1:0][W-1:0]  duty_act;
   logic [CH_NUM-1:0]         out_r;
   logic                      period_start_r;

   // Saturating step, evaluated one bit wider so neither direction can wrap.
   function automatic logic [W-1:0] step_duty(input logic [W-1:0] d,
                                               input logic up, input logic dn);
      logic [W:0] ext;
      logic [W:0] sum;
      ext       = {1'b0, d};
      sum       = ext + STEP_V;
      step_duty = d;
      if (up && !dn)
         step_duty = (sum > CNT_MAX) ? CNT_MAX[W-1:0] : sum[W-1:0];
      else if (dn && !up)
         step_duty = (ext < STEP_V) ? '0 : d - STEP_V[W-1:0];
   endfunction

`ifdef PWM_CENTER_ALIGN_EN
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   dir_t dir, dir_next;

   always_ff @(posedge clk) begin
      if (rst) dir <= DIR_UP;
      else     dir <= dir_next;
   end

   // Each extreme is held for two cycles: the turn-around cycle keeps cnt.
   always_comb begin
      dir_next = dir;
      cnt_next = cnt;
      commit   = 1'b0;
      case (dir)
         DIR_UP: begin
            if (cnt == CNT_LAST) dir_next = DIR_DOWN;
            else                 cnt_next = cnt + 1'b1;
         end
         DIR_DOWN: begin
            if (cnt == '0) begin
               dir_next = DIR_UP;
               commit   = 1'b1;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: dir_next = DIR_UP;
      endcase
   end

   assign at_start = (cnt == '0) && (dir == DIR_UP);
`else
   always_comb begin
      commit   = (cnt == CNT_LAST);
      cnt_next = commit ? '0 : cnt + 1'b1;
   end

   assign at_start = (cnt == '0);
`endif

   assign up_press = up_r & ~up_prev;
   assign dn_press = dn_r & ~dn_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         out_r          <= '0;
         period_start_r <= 1'b0;
         up_r           <= '0;
         up_prev        <= '0;
         dn_r           <= '0;
         dn_prev        <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            duty_nxt[i] <= DUTY_RST;
            duty_act[i] <= DUTY_RST;
         end
      end else begin
         cnt            <= cnt_next;
         period_start_r <= at_start;
         up_r           <= bus.key_up;
         up_prev        <= up_r;
         dn_r           <= bus.key_down;
         dn_prev        <= dn_r;
         // Commit takes the pending value from before this edge's step, so a
         // press landing in the wrap cycle waits for the following boundary.
         for (int i = 0; i < CH_NUM; i++) begin
            out_r[i]    <= (cnt < duty_act[i]);
            duty_nxt[i] <= step_duty(duty_nxt[i], up_press[i], dn_press[i]);
            if (commit) duty_act[i] <= duty_nxt[i];
         end
      end
   end

   assign bus.out          = out_r;
   assign bus.period_start = period_start_r;
   assign bus.duty         = duty_act;
endmodule

// File: tb/tb_pwm_multi_controller.sv
// Bench for pwm_multi_controller: period-position model compared every cycle plus directed literal checks.
module tb_pwm_multi_controller;
`ifdef PWM_CENTER_ALIGN_EN
   localparam bit CENTER = 1'b1;
`else
   localparam bit CENTER = 1'b0;
`endif
   localparam int PL = CENTER ? 16 : 8;
   localparam int NI = 2;
   localparam int P_CNT  [NI] = '{8, 8};
   localparam int P_CH   [NI] = '{2, 1};
   localparam int P_STEP [NI] = '{1, 3};
   localparam int P_INIT [NI] = '{4, 7};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pwm_multi_controller_if #(.CH_NUM(2), .W(4)) if0 ();
   pwm_multi_controller_if #(.CH_NUM(1), .W(4)) if1 ();

   pwm_multi_controller #(.CNT_NUM(8), .CH_NUM(2), .STEP(1), .DUTY_INIT(4)) dut (
      .clk(clk), .rst(rst), .bus(if0)
   );
   pwm_multi_controller #(.CNT_NUM(8), .CH_NUM(1), .STEP(3), .DUTY_INIT(7)) dut3 (
      .clk(clk), .rst(rst), .bus(if1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: position within the period, committed and pending duty, key history.
   int        m_pos  [NI];
   int        m_duty [NI][2];
   int        m_pend [NI][2];
   bit        m_kup  [NI][2];
   bit        m_kdn  [NI][2];
   bit        m_pup  [NI][2];
   bit        m_pdn  [NI][2];
   bit [1:0]  m_out  [NI];
   bit        m_ps   [NI];
   bit        m_valid = 1'b0;

   task automatic model_step(input int n, input bit r, input logic [1:0] ku, input logic [1:0] kd);
      int plen;
      int c;
      plen = CENTER ? 2 * P_CNT[n] : P_CNT[n];
      if (r) begin
         m_pos[n] = 0;
         m_out[n] = '0;
         m_ps[n]  = 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            m_duty[n][ch] = P_INIT[n];
            m_pend[n][ch] = P_INIT[n];
            m_kup[n][ch]  = 1'b0;
            m_kdn[n][ch]  = 1'b0;
            m_pup[n][ch]  = 1'b0;
            m_pdn[n][ch]  = 1'b0;
         end
         return;
      end
      // Counter value seen at this position of the period.
      c = (!CENTER || m_pos[n] < P_CNT[n]) ? m_pos[n] : 2 * P_CNT[n] - 1 - m_pos[n];
      m_ps[n] = (m_pos[n] == 0);
      for (int ch = 0; ch < P_CH[n]; ch++) begin
         m_out[n][ch] = (c < m_duty[n][ch]);
         if (m_pos[n] == plen - 1) m_duty[n][ch] = m_pend[n][ch];
         if (m_pup[n][ch] && !m_pdn[n][ch])
            m_pend[n][ch] = (m_pend[n][ch] + P_STEP[n] > P_CNT[n]) ? P_CNT[n] : m_pend[n][ch] + P_STEP[n];
         else if (m_pdn[n][ch] && !m_pup[n][ch])
            m_pend[n][ch] = (m_pend[n][ch] < P_STEP[n]) ? 0 : m_pend[n][ch] - P_STEP[n];
         m_pup[n][ch] = ku[ch] && !m_kup[n][ch];
         m_pdn[n][ch] = kd[ch] && !m_kdn[n][ch];
         m_kup[n][ch] = ku[ch];
         m_kdn[n][ch] = kd[ch];
      end
      m_pos[n] = (m_pos[n] + 1) % plen;
   endtask

   function automatic logic [31:0] exp_duty(input int n);
      logic [31:0] v;
      v = '0;
      for (int ch = 0; ch < P_CH[n]; ch++) v[ch*4 +: 4] = 4'(m_duty[n][ch]);
      return v;
   endfunction

   always @(posedge clk) begin
      model_step(0, rst, if0.key_up, if0.key_down);
      model_step(1, rst, {1'b0, if1.key_up}, {1'b0, if1.key_down});
      if (rst) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("out_i0",  32'(if0.out),          32'(m_out[0]));
         chk("ps_i0",   32'(if0.period_start), 32'(m_ps[0]));
         chk("duty_i0", 32'(if0.duty),         exp_duty(0));
         chk("out_i1",  32'(if1.out),          32'(m_out[1]));
         chk("ps_i1",   32'(if1.period_start), 32'(m_ps[1]));
         chk("duty_i1", 32'(if1.duty),         exp_duty(1));
      end
   end

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic set_key(input int n, input bit up, input int ch, input logic v);
      if (n == 0) begin
         if (up) if0.key_up[ch] = v;
         else    if0.key_down[ch] = v;
      end else begin
         if (up) if1.key_up[0] = v;
         else    if1.key_down[0] = v;
      end
   endtask

   task automatic press(input int n, input bit up, input int ch);
      set_key(n, up, ch, 1'b1);
      tick(2);
      set_key(n, up, ch, 1'b0);
      tick(2);
   endtask

   task automatic wait_ps0();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (if0.period_start === 1'b1) found = 1'b1;
      end
      chk("ps_wait", 32'(found), 32'd1);
   endtask

   task automatic count_win(input int n, input int ch, input int len, output int hi, output int ps);
      hi = 0;
      ps = 0;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         if (n == 0) begin
            hi += int'(if0.out[ch]);
            ps += int'(if0.period_start);
         end else begin
            hi += int'(if1.out[0]);
            ps += int'(if1.period_start);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  pat;
      logic [15:0] pat3;
      int hi, ps;
      pat = 8'b1111_0000;
`ifdef PWM_CENTER_ALIGN_EN
      pat3 = 16'b1110_0000_0000_0111;
`else
      pat3 = 16'b1110_0000_1110_0000;
`endif
      if0.key_up = '0; if0.key_down = '0;
      if1.key_up = '0; if1.key_down = '0;

      // Reset state
      tick(3);
      chk("rst_out",   32'(if0.out),          32'd0);
      chk("rst_ps",    32'(if0.period_start), 32'd0);
      chk("rst_duty",  32'(if0.duty),         32'h44);
      chk("rst_duty3", 32'(if1.duty),         32'h7);
      rst = 1'b0;

      // First period after release
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("first_out", 32'(if0.out), pat[7-k] ? 32'h3 : 32'h0);
         if (k == 0) chk("first_ps", 32'(if0.period_start), 32'd1);
      end

      // Single up press: pending until the boundary
      wait_ps0();
      set_key(0, 1'b1, 0, 1'b1);
      tick(1);
      set_key(0, 1'b1, 0, 1'b0);
      tick(2);
      chk("hold_duty", 32'(if0.duty), 32'h44);
      tick(PL + 2);
      chk("up1_duty", 32'(if0.duty), 32'h45);
      count_win(0, 0, PL, hi, ps);
      chk("up1_high", 32'(hi), 32'(5 * PL / 8));

      // Held key is one press; saturate at 8, then floor at 0
      set_key(0, 1'b1, 0, 1'b1);
      tick(40);
      set_key(0, 1'b1, 0, 1'b0);
      tick(2);
      for (int k = 0; k < 6; k++) press(0, 1'b1, 0);
      tick(PL + 4);
      chk("sat_duty", 32'(if0.duty), 32'h48);
      count_win(0, 0, PL, hi, ps);
      chk("sat_high", 32'(hi), 32'(PL));
      for (int k = 0; k < 9; k++) press(0, 1'b0, 0);
      tick(PL + 4);
      chk("zero_duty", 32'(if0.duty), 32'h40);
      count_win(0, 0, PL, hi, ps);
      chk("zero_high", 32'(hi), 32'd0);
      count_win(0, 1, PL, hi, ps);
      chk("ch1_high", 32'(hi), 32'(PL / 2));

      // Up and down rising together on channel 1
      if0.key_up[1] = 1'b1; if0.key_down[1] = 1'b1;
      tick(2);
      if0.key_up[1] = 1'b0; if0.key_down[1] = 1'b0;
      tick(PL + 4);
      chk("both_duty", 32'(if0.duty), 32'h40);

      // STEP=3 instance from 7
      press(1, 1'b1, 0);
      tick(PL + 4);
      chk("s3_up", 32'(if1.duty), 32'h8);
      count_win(1, 0, PL, hi, ps);
      chk("s3_high", 32'(hi), 32'(PL));
      press(1, 1'b0, 0);
      tick(PL + 4);
      chk("s3_dn1", 32'(if1.duty), 32'h5);
      press(1, 1'b0, 0);
      tick(PL + 4);
      chk("s3_dn2", 32'(if1.duty), 32'h2);

      // Duty 3 on channel 1: shape and period_start rate over 16 cycles
      press(0, 1'b0, 1);
      tick(PL + 4);
      chk("d3_duty", 32'(if0.duty), 32'h30);
      wait_ps0();
      hi = 0;
      ps = int'(if0.period_start);
      chk("d3_shape", 32'(if0.out[1]), 32'(pat3[15]));
      hi += int'(if0.out[1]);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         chk("d3_shape", 32'(if0.out[1]), 32'(pat3[15-k]));
         hi += int'(if0.out[1]);
         ps += int'(if0.period_start);
      end
      chk("d3_high", 32'(hi), 32'd6);
      chk("d3_ps", 32'(ps), CENTER ? 32'd1 : 32'd2);

      // Reset mid-period drops a pending change
      wait_ps0();
      set_key(0, 1'b1, 0, 1'b1);
      tick(1);
      set_key(0, 1'b1, 0, 1'b0);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("mrst_out",   32'(if0.out),          32'd0);
      chk("mrst_ps",    32'(if0.period_start), 32'd0);
      chk("mrst_duty",  32'(if0.duty),         32'h44);
      chk("mrst_duty3", 32'(if1.duty),         32'h7);
      rst = 1'b0;
      tick(PL + 4);
      chk("mrst_lost", 32'(if0.duty), 32'h44);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
